// File: rtl/rt_pkg.sv
// -----------------------------------------------------------------------------
// rt_pkg
// Shared ray-tracing definitions: the signed Q16.16 fixed-point type and its
// limit constants, the packed ray width, and the ray dispatcher state encoding.
// -----------------------------------------------------------------------------
package rt_pkg;

    // Signed Q16.16 fixed point.
    typedef logic signed [31:0] fip;

    localparam fip FIP_ONE = 32'sh0001_0000;
    localparam fip FIP_MAX = 32'sh7fff_ffff;
    localparam fip FIP_MIN = 32'sh8000_0000;

    // {dir z,y,x, origin z,y,x}, six Q16.16 words; origin occupies [95:0].
    localparam int RAY_W = 192;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        WAIT,
        DONE,
        FAULT
    } disp_state_t;

endpackage

// File: rtl/ray_dispatcher.sv
// -----------------------------------------------------------------------------
// ray_dispatcher
// Per-ray batch controller in front of tri_insector. Accepts one ray at a time,
// launches a full triangle batch, waits for the batch to finish (or time out),
// and returns the closest-hit result tagged with the ray ID.
//
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   i_valid / o_ready               ray input handshake
//   i_ray, i_ray_id                 ray and its tag
//   i_baseaddr, i_tri_cnt           triangle table base and count
//   ins_ivalid                      one-cycle batch start to the insector
//   ins_baseaddr, ins_ray,
//   ins_tri_cnt                     latched batch parameters for the insector
//   ins_hit, ins_t, ins_tri_index,
//   ins_finish                      insector result and batch-done level
//   o_valid / i_ready               result output handshake
//   o_ray_id, o_hit, o_t,
//   o_tri_index, o_err              result fields (o_err: produced by timeout)
//   o_fault                         sticky timeout indicator
//   o_ray_count                     results delivered, wraps at 2^32
// -----------------------------------------------------------------------------
module ray_dispatcher
    import rt_pkg::*;
#(
    parameter int ID_W    = 16,
    parameter int TIMEOUT = 1048576
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_valid,
    output logic              o_ready,
    input  logic [RAY_W-1:0]  i_ray,
    input  logic [ID_W-1:0]   i_ray_id,
    input  logic [31:0]       i_baseaddr,
    input  logic [31:0]       i_tri_cnt,

    output logic              ins_ivalid,
    output logic [31:0]       ins_baseaddr,
    output logic [RAY_W-1:0]  ins_ray,
    output logic [31:0]       ins_tri_cnt,
    input  logic              ins_hit,
    input  fip                ins_t,
    input  logic [31:0]       ins_tri_index,
    input  logic              ins_finish,

    output logic              o_valid,
    input  logic              i_ready,
    output logic [ID_W-1:0]   o_ray_id,
    output logic              o_hit,
    output fip                o_t,
    output logic [31:0]       o_tri_index,
    output logic              o_err,
    output logic              o_fault,
    output logic [31:0]       o_ray_count
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    disp_state_t      state;
    disp_state_t      state_next;
    logic [CNT_W-1:0] timer;
    logic             out_of_reset;

    logic accept;
    logic take_finish;
    logic take_timeout;
    logic deliver;

    // out_of_reset is low for the cycle following a reset edge, keeping
    // o_ready a pure decode of registered state while still reading 0 there.
    assign o_ready = out_of_reset && (state == IDLE);

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        take_finish  = 1'b0;
        take_timeout = 1'b0;
        deliver      = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_valid && o_ready) begin
                    accept     = 1'b1;
                    state_next = (i_tri_cnt == 32'd0) ? DONE : LAUNCH;
                end
            end
            LAUNCH: state_next = ARM;
            // ins_finish is still high from the previous batch here; ignore it.
            ARM:    state_next = WAIT;
            WAIT: begin
                // Finish has priority over a coincident timeout.
                if (ins_finish) begin
                    take_finish = 1'b1;
                    state_next  = DONE;
                end else if (timer == CNT_LAST) begin
                    take_timeout = 1'b1;
                    state_next   = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    deliver    = 1'b1;
                    state_next = o_fault ? FAULT : IDLE;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: the data registers are reset too, since their reset values are
    // visible on output ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_of_reset <= 1'b0;
            timer        <= '0;
            ins_ivalid   <= 1'b0;
            ins_baseaddr <= '0;
            ins_ray      <= '0;
            ins_tri_cnt  <= '0;
            o_valid      <= 1'b0;
            o_ray_id     <= '0;
            o_hit        <= 1'b0;
            o_t          <= '0;
            o_tri_index  <= '0;
            o_err        <= 1'b0;
            o_fault      <= 1'b0;
            o_ray_count  <= '0;
        end else begin
            out_of_reset <= 1'b1;
            ins_ivalid   <= (state_next == LAUNCH);
            o_valid      <= (state_next == DONE);

            if (state == ARM)
                timer <= '0;
            else if (state == WAIT)
                timer <= timer + CNT_W'(1);

            // The result defaults to a clean miss on accept; a zero-count ray
            // is delivered exactly like this without launching a batch.
            if (accept) begin
                ins_ray      <= i_ray;
                ins_baseaddr <= i_baseaddr;
                ins_tri_cnt  <= i_tri_cnt;
                o_ray_id     <= i_ray_id;
                o_hit        <= 1'b0;
                o_t          <= FIP_MAX;
                o_tri_index  <= '0;
                o_err        <= 1'b0;
            end

            if (take_finish) begin
                o_hit       <= ins_hit;
                o_t         <= ins_t;
                o_tri_index <= ins_tri_index;
                o_err       <= 1'b0;
            end

            if (take_timeout) begin
                o_hit       <= 1'b0;
                o_t         <= FIP_MAX;
                o_tri_index <= '0;
                o_err       <= 1'b1;
                o_fault     <= 1'b1;
            end

            if (deliver)
                o_ray_count <= o_ray_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_ray_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_ray_dispatcher
// Directed bench for ray_dispatcher. Instance "a" uses the default timeout and
// covers hit, zero-count and backpressure; instance "b" uses TIMEOUT=8 and
// covers coincidence, timeout/fault and reset mid-WAIT. Each instance has a
// small behavioural insector: finish stays high through ARM, then drops and
// rises again m_delay cycles after the launch cycle (never, if m_hang).
// -----------------------------------------------------------------------------
module tb_ray_dispatcher;
    import rt_pkg::*;

    localparam int ID_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic use_b;

    // Shared stimulus
    logic             i_valid, i_ready;
    logic [RAY_W-1:0] i_ray;
    logic [ID_W-1:0]  i_ray_id;
    logic [31:0]      i_baseaddr, i_tri_cnt;

    // Insector model controls
    int          m_delay;
    logic        m_hang;
    logic        m_hit;
    logic [31:0] m_t;
    logic [31:0] m_idx;

    // Per-instance wiring
    logic             a_i_valid, a_i_ready, b_i_valid, b_i_ready;
    logic             a_o_ready, b_o_ready;
    logic             a_ins_ivalid, b_ins_ivalid;
    logic [31:0]      a_ins_baseaddr, b_ins_baseaddr;
    logic [RAY_W-1:0] a_ins_ray, b_ins_ray;
    logic [31:0]      a_ins_tri_cnt, b_ins_tri_cnt;
    logic             a_ins_finish, b_ins_finish;
    logic             a_o_valid, b_o_valid;
    logic [ID_W-1:0]  a_o_ray_id, b_o_ray_id;
    logic             a_o_hit, b_o_hit;
    fip               a_o_t, b_o_t;
    logic [31:0]      a_o_tri_index, b_o_tri_index;
    logic             a_o_err, b_o_err;
    logic             a_o_fault, b_o_fault;
    logic [31:0]      a_o_ray_count, b_o_ray_count;

    assign a_i_valid = i_valid & ~use_b;
    assign a_i_ready = i_ready & ~use_b;
    assign b_i_valid = i_valid &  use_b;
    assign b_i_ready = i_ready &  use_b;

    ray_dispatcher #(.ID_W(ID_W)) dut_a (
        .clk(clk), .reset(reset),
        .i_valid(a_i_valid), .o_ready(a_o_ready), .i_ray(i_ray), .i_ray_id(i_ray_id),
        .i_baseaddr(i_baseaddr), .i_tri_cnt(i_tri_cnt),
        .ins_ivalid(a_ins_ivalid), .ins_baseaddr(a_ins_baseaddr), .ins_ray(a_ins_ray),
        .ins_tri_cnt(a_ins_tri_cnt), .ins_hit(m_hit), .ins_t(m_t), .ins_tri_index(m_idx),
        .ins_finish(a_ins_finish),
        .o_valid(a_o_valid), .i_ready(a_i_ready), .o_ray_id(a_o_ray_id), .o_hit(a_o_hit),
        .o_t(a_o_t), .o_tri_index(a_o_tri_index), .o_err(a_o_err), .o_fault(a_o_fault),
        .o_ray_count(a_o_ray_count)
    );

    ray_dispatcher #(.ID_W(ID_W), .TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset),
        .i_valid(b_i_valid), .o_ready(b_o_ready), .i_ray(i_ray), .i_ray_id(i_ray_id),
        .i_baseaddr(i_baseaddr), .i_tri_cnt(i_tri_cnt),
        .ins_ivalid(b_ins_ivalid), .ins_baseaddr(b_ins_baseaddr), .ins_ray(b_ins_ray),
        .ins_tri_cnt(b_ins_tri_cnt), .ins_hit(m_hit), .ins_t(m_t), .ins_tri_index(m_idx),
        .ins_finish(b_ins_finish),
        .o_valid(b_o_valid), .i_ready(b_i_ready), .o_ray_id(b_o_ray_id), .o_hit(b_o_hit),
        .o_t(b_o_t), .o_tri_index(b_o_tri_index), .o_err(b_o_err), .o_fault(b_o_fault),
        .o_ray_count(b_o_ray_count)
    );

    // Insector models: age is the number of cycles since the launch cycle.
    int   a_age, b_age;
    logic a_busy, b_busy;

    always @(posedge clk) begin
        if (reset) begin
            a_busy <= 1'b0; a_age <= 0;
        end else if (a_ins_ivalid) begin
            a_busy <= 1'b1; a_age <= 1;
        end else if (a_busy) begin
            a_age <= a_age + 1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            b_busy <= 1'b0; b_age <= 0;
        end else if (b_ins_ivalid) begin
            b_busy <= 1'b1; b_age <= 1;
        end else if (b_busy) begin
            b_age <= b_age + 1;
        end
    end

    assign a_ins_finish = !a_busy || (a_age < 2) || (!m_hang && a_age >= m_delay);
    assign b_ins_finish = !b_busy || (b_age < 2) || (!m_hang && b_age >= m_delay);

    // Views of the selected instance
    logic             o_ready, ins_ivalid, o_valid, o_hit, o_err, o_fault;
    logic [31:0]      ins_baseaddr, ins_tri_cnt, o_tri_index, o_ray_count;
    logic [RAY_W-1:0] ins_ray;
    logic [ID_W-1:0]  o_ray_id;
    fip               o_t;

    assign o_ready      = use_b ? b_o_ready      : a_o_ready;
    assign ins_ivalid   = use_b ? b_ins_ivalid   : a_ins_ivalid;
    assign ins_baseaddr = use_b ? b_ins_baseaddr : a_ins_baseaddr;
    assign ins_ray      = use_b ? b_ins_ray      : a_ins_ray;
    assign ins_tri_cnt  = use_b ? b_ins_tri_cnt  : a_ins_tri_cnt;
    assign o_valid      = use_b ? b_o_valid      : a_o_valid;
    assign o_ray_id     = use_b ? b_o_ray_id     : a_o_ray_id;
    assign o_hit        = use_b ? b_o_hit        : a_o_hit;
    assign o_t          = use_b ? b_o_t          : a_o_t;
    assign o_tri_index  = use_b ? b_o_tri_index  : a_o_tri_index;
    assign o_err        = use_b ? b_o_err        : a_o_err;
    assign o_fault      = use_b ? b_o_fault      : a_o_fault;
    assign o_ray_count  = use_b ? b_o_ray_count  : a_o_ray_count;

    // Launch pulses of the selected instance, sampled mid-cycle.
    int n_launch = 0;
    always @(negedge clk) if (ins_ivalid === 1'b1) n_launch++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_flags"}, {o_valid, ins_ivalid, o_hit, o_err, o_fault, o_ready}, 6'b0);
        check({pfx, "_result"}, {o_t, o_tri_index, o_ray_count, o_ray_id}, '0);
        check({pfx, "_ins"}, {ins_ray, ins_baseaddr, ins_tri_cnt}, '0);
    endtask

    // Called just after a posedge; returns just after the accept edge (cycle 1).
    task automatic send_ray(input logic [ID_W-1:0] id, input logic [31:0] cnt,
                            input logic [31:0] base, input logic [RAY_W-1:0] ray);
        int n = 0;
        i_valid = 1'b1; i_ray_id = id; i_tri_cnt = cnt; i_baseaddr = base; i_ray = ray;
        @(negedge clk);
        while (!o_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", o_ready, 1'b1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Returns at the negedge of the first o_valid cycle; lat is its cycle index.
    task automatic wait_result(input int start, output int lat);
        lat = start;
        @(negedge clk);
        while (!o_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
    endtask

    localparam logic [RAY_W-1:0] RAY1 = 192'h0001_0000_0002_0000_0003_0000_0004_0000_0005_0000_0006_0000;
    localparam logic [RAY_W-1:0] RAY2 = 192'hffff_0000_0000_8000_1234_5678_9abc_def0_0f0f_0f0f_f0f0_f0f0;
    localparam logic [RAY_W-1:0] RAY3 = 192'hdead_beef_cafe_f00d_0123_4567_89ab_cdef_1111_2222_3333_4444;
    localparam logic [RAY_W-1:0] RAY4 = 192'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int launch0;

        reset = 1'b1; use_b = 1'b0;
        i_valid = 1'b0; i_ready = 1'b0; i_ray = '0; i_ray_id = '0;
        i_baseaddr = '0; i_tri_cnt = '0;
        m_delay = 20; m_hang = 1'b0; m_hit = 1'b0; m_t = '0; m_idx = '0;

        // ---------------- Reset ----------------
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_values("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_still_low", o_ready, 1'b0);
        @(negedge clk);
        check("rst_ready_after_release", o_ready, 1'b1);
        @(posedge clk);
        #1;

        // ---------------- Hit ray ----------------
        m_delay = 20; m_hang = 1'b0; m_hit = 1'b1; m_t = 32'h0002_0000; m_idx = 32'd1;
        launch0 = n_launch;
        send_ray(16'hA001, 32'd3, 32'h1000_0000, RAY1);
        @(negedge clk);
        check("hit_ivalid_c1", ins_ivalid, 1'b1);
        check("hit_ins_params", {ins_ray, ins_baseaddr, ins_tri_cnt}, {RAY1, 32'h1000_0000, 32'd3});
        wait_result(2, lat);
        check("hit_latency", lat, 22);
        check("hit_result", {o_ray_id, o_hit, o_t, o_tri_index, o_err},
              {16'hA001, 1'b1, 32'h0002_0000, 32'd1, 1'b0});
        check("hit_one_launch", n_launch - launch0, 1);
        take_result();
        @(negedge clk);
        check("hit_after_handshake", {o_valid, o_ready, o_ray_count}, {1'b0, 1'b1, 32'd1});
        @(posedge clk);
        #1;

        // ---------------- Zero-count ray ----------------
        launch0 = n_launch;
        send_ray(16'hB002, 32'd0, 32'h2000_0000, RAY2);
        @(negedge clk);
        check("zero_valid_c1", o_valid, 1'b1);
        check("zero_result", {o_ray_id, o_hit, o_t, o_tri_index, o_err},
              {16'hB002, 1'b0, 32'h7fff_ffff, 32'd0, 1'b0});

        // ---------------- Backpressure ----------------
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b1; i_ray_id = ID_W'(16'hC000 + i); i_tri_cnt = 32'd0;
            i_ray = RAY4 ^ RAY_W'(i); i_baseaddr = 32'h4000_0000 + 32'(i);
            @(negedge clk);
            check("bp_hold", {o_valid, o_ready, o_ray_id, o_hit, o_t, o_tri_index, o_err},
                  {1'b1, 1'b0, 16'hB002, 1'b0, 32'h7fff_ffff, 32'd0, 1'b0});
        end
        check("zero_no_launch", n_launch - launch0, 0);
        m_delay = 5; m_hit = 1'b1; m_t = 32'h0001_0000; m_idx = 32'd4;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        i_valid = 1'b1; i_ray_id = 16'hD003; i_tri_cnt = 32'd2;
        i_baseaddr = 32'h3000_0000; i_ray = RAY3;
        @(negedge clk);
        check("bp_after_handshake", {o_valid, o_ready, o_ray_count}, {1'b0, 1'b1, 32'd2});
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("bp_accept_next_cycle", {ins_ivalid, ins_ray, ins_baseaddr, ins_tri_cnt},
              {1'b1, RAY3, 32'h3000_0000, 32'd2});
        wait_result(2, lat);
        check("bp_ray3_latency", lat, 7);
        check("bp_ray3_result", {o_ray_id, o_hit, o_t, o_tri_index, o_err},
              {16'hD003, 1'b1, 32'h0001_0000, 32'd4, 1'b0});
        take_result();
        @(negedge clk);
        check("bp_count", o_ray_count, 32'd3);
        @(posedge clk);
        #1;

        // ---------------- Coincidence (TIMEOUT=8) ----------------
        use_b = 1'b1;
        m_delay = 9; m_hang = 1'b0; m_hit = 1'b1; m_t = 32'h0003_0000; m_idx = 32'd7;
        send_ray(16'hE004, 32'd5, 32'h5000_0000, RAY1);
        @(negedge clk);
        check("coin_ivalid_c1", ins_ivalid, 1'b1);
        wait_result(2, lat);
        check("coin_latency", lat, 11);
        check("coin_result", {o_ray_id, o_hit, o_t, o_tri_index, o_err, o_fault},
              {16'hE004, 1'b1, 32'h0003_0000, 32'd7, 1'b0, 1'b0});
        take_result();
        @(posedge clk);
        #1;

        // ---------------- Timeout ----------------
        m_hang = 1'b1;
        send_ray(16'hF005, 32'd5, 32'h6000_0000, RAY2);
        wait_result(1, lat);
        check("to_latency", lat, 11);
        check("to_result", {o_ray_id, o_hit, o_t, o_tri_index, o_err, o_fault},
              {16'hF005, 1'b0, 32'h7fff_ffff, 32'd0, 1'b1, 1'b1});
        take_result();
        launch0 = n_launch;
        i_valid = 1'b1; i_ray_id = 16'h0bad; i_tri_cnt = 32'd0; i_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("fault_locked", {o_ready, o_valid, o_fault}, 3'b001);
        end
        check("fault_no_launch", n_launch - launch0, 0);
        check("fault_count", o_ray_count, 32'd2);
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_ready = 1'b0;

        // ---------------- Reset mid-WAIT ----------------
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("clr_fault", o_fault, 1'b0);
        @(posedge clk);
        #1;
        m_hang = 1'b1;
        send_ray(16'h1006, 32'd4, 32'h7000_0000, RAY4);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_wait_busy", {o_valid, o_ready}, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values("mid_rst");
        @(negedge clk);
        check("mid_rst_ready", o_ready, 1'b1);
        @(posedge clk);
        #1;
        send_ray(16'h2007, 32'd0, 32'h8000_0000, RAY3);
        @(negedge clk);
        check("post_rst_zero", {o_valid, o_ray_id, o_err}, {1'b1, 16'h2007, 1'b0});
        take_result();
        @(negedge clk);
        check("post_rst_count", o_ray_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
